// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM ramp generator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int W_DEF    = 8;
    localparam int PS_W_DEF = 8;

    // Ramp shape selectors for the mode input.
    localparam logic MODE_SAW = 1'b0;
    localparam logic MODE_TRI = 1'b1;

    // Triangle slope direction.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: emits a ramp-advance tick once every prescale+1 enabled cycles.
// Latency: tick is combinational from the registered count.
// Backpressure: none; en=0 freezes the count and suppresses tick.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PS_W = PS_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [PS_W-1:0] prescale,
    output logic            tick
);

    logic [PS_W-1:0] ps_cnt_q;
    logic [PS_W-1:0] ps_cnt_d;

    // Equality only: if prescale is lowered below the count, the count wraps through 2^PS_W.
    assign tick = en && (ps_cnt_q == prescale);

    // Next count: restart on tick, otherwise advance while enabled.
    always_comb begin
        ps_cnt_d = ps_cnt_q;
        if (en) begin
            ps_cnt_d = tick ? '0 : ps_cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_gen.sv
// Ramp (comparator A) and active duty (comparator B) generator for glitch-free PWM.
// Latency: ramp/duty/period_start registered; load_ready combinational from pend register.
// Backpressure: one-entry shadow; load_ready low while a load waits for the next period boundary.
module pwm_ramp_gen
    import pwm_pkg::*;
#(
    parameter int             W        = W_DEF,
    parameter int             PS_W     = PS_W_DEF,
    parameter logic [W-1:0]   TOP_RST  = {W{1'b1}},
    parameter logic [W-1:0]   DUTY_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [PS_W-1:0] prescale,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [W-1:0]    load_duty,
    input  logic [W-1:0]    load_top,
    output logic [W-1:0]    ramp,
    output logic [W-1:0]    duty,
    output logic            period_start
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic         tick;
    logic         bnd;
    logic         accept;

    logic [W-1:0] ramp_q, ramp_d;
    dir_e         dir_q, dir_d;
    logic         mode_q, mode_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] top_q, top_d;
    logic [W-1:0] sh_duty_q, sh_duty_d;
    logic [W-1:0] sh_top_q, sh_top_d;
    logic         pend_q, pend_d;
    logic         pstart_q, pstart_d;

    pwm_prescaler #(.PS_W(PS_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    assign load_ready   = !pend_q;
    assign accept       = load_valid && !pend_q;
    assign ramp         = ramp_q;
    assign duty         = duty_q;
    assign period_start = pstart_q;

    // Ramp stepping and slope direction; flags the period boundary when the ramp returns to 0.
    always_comb begin
        ramp_d = ramp_q;
        dir_d  = dir_q;
        bnd    = 1'b0;
        if (tick) begin
            if (mode_q == MODE_SAW) begin
                if (ramp_q == top_q) begin
                    ramp_d = '0;
                    bnd    = 1'b1;
                end else begin
                    ramp_d = ramp_q + ONE;
                end
            end else if (dir_q == DIR_UP) begin
                if (ramp_q == top_q) begin
                    // top of 0 or 1 turns straight back to 0, which closes the period.
                    if (top_q <= ONE) begin
                        ramp_d = '0;
                        dir_d  = DIR_UP;
                        bnd    = 1'b1;
                    end else begin
                        ramp_d = top_q - ONE;
                        dir_d  = DIR_DOWN;
                    end
                end else begin
                    ramp_d = ramp_q + ONE;
                end
            end else begin
                if (ramp_q == ONE) begin
                    ramp_d = '0;
                    dir_d  = DIR_UP;
                    bnd    = 1'b1;
                end else begin
                    ramp_d = ramp_q - ONE;
                end
            end
        end
    end

    // Shadow load, boundary apply of duty/top/mode, and the boundary pulse.
    always_comb begin
        mode_d    = mode_q;
        duty_d    = duty_q;
        top_d     = top_q;
        sh_duty_d = sh_duty_q;
        sh_top_d  = sh_top_q;
        pend_d    = pend_q;
        pstart_d  = bnd;
        if (bnd) begin
            mode_d = mode;
            if (pend_q) begin
                duty_d = sh_duty_q;
                top_d  = sh_top_q;
                pend_d = 1'b0;
            end
        end
        // accept implies pend_q=0, so it never collides with the apply above;
        // a load taken on a boundary edge therefore waits for the following boundary.
        if (accept) begin
            if (en) begin
                sh_duty_d = load_duty;
                sh_top_d  = load_top;
                pend_d    = 1'b1;
            end else begin
                // Ramp is frozen, so there is no period edge to wait for.
                duty_d = load_duty;
                top_d  = load_top;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q    <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_SAW;
            duty_q    <= DUTY_RST;
            top_q     <= TOP_RST;
            sh_duty_q <= '0;
            sh_top_q  <= '0;
            pend_q    <= 1'b0;
            pstart_q  <= 1'b0;
        end else begin
            ramp_q    <= ramp_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            top_q     <= top_d;
            sh_duty_q <= sh_duty_d;
            sh_top_q  <= sh_top_d;
            pend_q    <= pend_d;
            pstart_q  <= pstart_d;
        end
    end

endmodule
